// File: rtl/fpm_pkg.sv
// Shared constants, FSM state type and Booth digit decode for the sequential
// radix-4 significand multiplier.
package fpm_pkg;

  localparam int SIG_W = 24;
  localparam int NDIG  = SIG_W / 2 + 1;
  localparam int ACC_W = 2 * SIG_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  // Radix-4 Booth recoding of one {b[2i+1], b[2i], b[2i-1]} triple.
  function automatic booth_digit_t booth_decode(input logic [2:0] trip);
    booth_digit_t dig;
    dig = '0;
    case (trip)
      3'b001, 3'b010: dig.one = 1'b1;
      3'b011:         dig.two = 1'b1;
      3'b100: begin
        dig.neg = 1'b1;
        dig.two = 1'b1;
      end
      3'b101, 3'b110: begin
        dig.neg = 1'b1;
        dig.one = 1'b1;
      end
      default:        dig = '0;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth4_pp_sel.sv
// Combinational radix-4 Booth partial-product selector: one bit triple and the
// multiplicand in, sign-extended unshifted partial product out.
module booth4_pp_sel #(
  parameter int SIG_W = 24
) (
  input  logic [2:0]         triple,
  input  logic [SIG_W-1:0]   a,
  output logic [2*SIG_W+1:0] pp
);
  import fpm_pkg::*;

  localparam int ACC_BITS = 2 * SIG_W + 2;

  booth_digit_t        dig_s;
  logic [ACC_BITS-1:0] mag_s;

  // Select |d|*a, then negate in two's complement for negative digits.
  always_comb begin
    dig_s = booth_decode(triple);
    mag_s = '0;
    if (dig_s.two) begin
      mag_s = {{(SIG_W + 1){1'b0}}, a, 1'b0};
    end else if (dig_s.one) begin
      mag_s = {{(SIG_W + 2){1'b0}}, a};
    end else begin
      mag_s = '0;
    end
    if (dig_s.neg) begin
      pp = ~mag_s + {{(ACC_BITS - 1){1'b0}}, 1'b1};
    end else begin
      pp = mag_s;
    end
  end

endmodule

// File: rtl/booth4_seq_mul.sv
// Sequential radix-4 Booth unsigned multiplier, one digit per clock.
// Build option: define FPM_STICKY_EN to generate the sticky output; otherwise it is tied low.
module booth4_seq_mul #(
  parameter int SIG_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIG_W-1:0]     a,
  input  logic [SIG_W-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*SIG_W-1:0]   prod,
  output logic                 sticky
);
  import fpm_pkg::*;

  localparam int N_DIG    = SIG_W / 2 + 1;
  localparam int ACC_BITS = 2 * SIG_W + 2;
  localparam int CNT_W    = $clog2(N_DIG + 1);
  localparam int BX_W     = 2 * N_DIG + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

  state_t               state_r, state_nxt_s;
  logic [SIG_W-1:0]     a_r, b_r;
  logic [ACC_BITS-1:0]  acc_r, pp_s, pp_shift_s, acc_sum_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*SIG_W-1:0]   prod_r;
  logic                 out_valid_r, in_ready_r;
  logic [BX_W-1:0]      b_ext_s, b_shift_s;
  logic [2:0]           triple_s;
  logic                 accept_s, last_s;

  // b with an implicit 0 below bit 0 and zero padding above the top digit.
  assign b_ext_s    = {{(BX_W - SIG_W - 1){1'b0}}, b_r, 1'b0};
  assign b_shift_s  = b_ext_s >> {cnt_r, 1'b0};
  assign triple_s   = b_shift_s[2:0];
  assign pp_shift_s = pp_s << {cnt_r, 1'b0};
  assign acc_sum_s  = acc_r + pp_shift_s;
  assign accept_s   = in_valid && in_ready_r;
  assign last_s     = (cnt_r == LAST_CNT);

  booth4_pp_sel #(.SIG_W(SIG_W)) u_pp_sel (
    .triple (triple_s),
    .a      (a_r),
    .pp     (pp_s)
  );

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Operand latch, accumulator, digit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= '0;
      b_r         <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      prod_r      <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        RUN: begin
          acc_r <= acc_sum_s;
          cnt_r <= cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          if (last_s) begin
            prod_r      <= acc_sum_s[2*SIG_W-1:0];
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

`ifdef FPM_STICKY_EN
  logic sticky_r;

  // Sticky captures the low product bits only when the result is published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 1'b0;
    end else if (state_r == RUN && last_s) begin
      sticky_r <= |acc_sum_s[SIG_W-2:0];
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign sticky = sticky_r;
`else
  assign sticky = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign prod      = prod_r;

endmodule

// File: tb/tb_booth4_seq_mul.sv
// Directed self-checking bench for booth4_seq_mul: latency, products, sticky,
// stall hold, mid-run reset and a short random sweep.
module tb_booth4_seq_mul;

  localparam int SIG_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, sticky;
  logic [SIG_W-1:0]  a, b;
  logic [2*SIG_W-1:0] prod;

  int checks   = 0;
  int failures = 0;

  booth4_seq_mul #(.SIG_W(SIG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .sticky    (sticky)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic exp_sticky(input logic [47:0] p);
`ifdef FPM_STICKY_EN
    return |p[22:0];
`else
    return 1'b0;
`endif
  endfunction

  // Offer one operand pair, scramble inputs mid-run, optionally stall in DONE, then drain.
  task automatic run_op(input string tag, input logic [23:0] av, input logic [23:0] bv,
                        input int stall);
    logic [47:0] exp_p;
    logic [47:0] held;
    int n;
    int w;
    exp_p = {24'd0, av} * {24'd0, bv};
    @(negedge clk);
    out_ready = 1'b0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 24'($urandom);
    b = 24'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'd13);
    check_eq({tag, "_prod"}, {16'd0, prod}, {16'd0, exp_p});
    check_eq({tag, "_sticky"}, {63'd0, sticky}, {63'd0, exp_sticky(exp_p)});
    held = prod;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = 24'($urandom);
      b = 24'($urandom);
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_prod"}, {16'd0, prod}, {16'd0, held});
      check_eq({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      check_eq({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #22;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_prod", {16'd0, prod}, 64'd0);
    check_eq("rst_sticky", {63'd0, sticky}, 64'd0);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", {63'd0, in_ready}, 64'd1);

    run_op("all_ones", 24'hFFFFFF, 24'hFFFFFF, 0);
    run_op("msb_sq", 24'h800000, 24'h800000, 0);
    run_op("three_five", 24'd3, 24'd5, 0);
    run_op("one_x", 24'h000001, 24'hABCDEF, 0);
    run_op("x_16", 24'h123456, 24'h000010, 0);
    run_op("alt_x2", 24'hAAAAAA, 24'h000002, 0);
    run_op("stall5", 24'h00F00D, 24'hBEEF01, 5);

    // Reset after six digits: nothing may be presented, outputs clear at once.
    @(negedge clk);
    a = 24'hFFFFFF;
    b = 24'h000123;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_prod", {16'd0, prod}, 64'd0);
    check_eq("midrst_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("zero_a", 24'd0, 24'h123456, 0);

    for (int k = 0; k < 200; k++) begin
      run_op("rand", 24'($urandom), 24'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
